// File: rtl/uart_tx_fifo_if.sv
// UART transmit FIFO port bundle.
// Push side, flow control, serial line and status.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8
);
  localparam int NW = $clog2(DEPTH + 1);

  logic                 wr_en;
  logic [DATA_BITS-1:0] data;
  logic                 CTS;
  logic                 RTS;
  logic                 serial_out;
  logic                 busy;
  logic                 full;
  logic                 empty;
  logic [NW-1:0]        count;
  logic                 overflow;

  modport master (
    output wr_en, data, CTS,
    input  RTS, serial_out, busy,
    input  full, empty, count, overflow
  );

  modport slave (
    input  wr_en, data, CTS,
    output RTS, serial_out, busy,
    output full, empty, count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO,
// with RTS/CTS handshake before every frame.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input logic          CLK,
  input logic          rst,
  uart_tx_fifo_if.slave u
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CLAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);
  localparam logic ODD = 1'(PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [NW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 rts_q, rts_d;
  logic                 so_q, so_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic full, empty, busy, bit_end, push, pop;

  assign full    = (count_q == NW'(DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q == S_START) || (state_q == S_DATA)
                || (state_q == S_PAR)   || (state_q == S_STOP);
  assign bit_end = (cnt_q == CLAST);

  // FIFO bookkeeping; a pop frees the slot a same-cycle push needs
  always_comb begin
    push    = u.wr_en && (!full || pop);
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (u.wr_en & full & ~pop);
  end

  // storage has no reset; only pointers define validity
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= u.data;
  end

  // frame sequencer: next state, counters and shift register
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (busy) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      S_IDLE: if (!empty) state_d = S_REQ;
      S_REQ: begin
        if (u.CTS && !empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          par_d   = (^mem_q[rptr_q]) ^ ODD;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DLAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PAR: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == SLAST) begin
            bit_d   = '0;
            state_d = empty ? S_IDLE : S_REQ;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // registered line and handshake outputs
  always_comb begin
    rts_d = (state_d == S_REQ);
    so_d  = 1'b1;
    unique case (state_q)
      S_START: so_d = 1'b0;
      S_DATA:  so_d = shift_q[0];
      S_PAR:   so_d = par_q;
      default: so_d = 1'b1;
    endcase
  end

  // state register; reset aborts any frame at once
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rts_q   <= 1'b0;
      so_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rts_q   <= rts_d;
      so_q    <= so_d;
    end
  end

  assign u.RTS        = rts_q;
  assign u.serial_out = so_q;
  assign u.busy       = busy;
  assign u.full       = full;
  assign u.empty      = empty;
  assign u.count      = count_q;
  assign u.overflow   = ovf_q;
endmodule
